// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one word at a time into a single-entry instruction
// register, pulses pc_inc per captured word and forwards branch redirects to the PC.
module fetch_unit #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pending, pending_nx;
  logic                pc_inc_nx, pc_load_nx, mem_req_nx, ir_valid_nx;
  logic [ADDR_W-1:0]   pc_target_nx, mem_addr_nx, ir_pc_nx;
  logic [DATA_W-1:0]   ir_data_nx;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      pc_inc    <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ir_valid  <= 1'b0;
      ir_data   <= '0;
      ir_pc     <= '0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      pc_inc    <= pc_inc_nx;
      pc_load   <= pc_load_nx;
      pc_target <= pc_target_nx;
      mem_req   <= mem_req_nx;
      mem_addr  <= mem_addr_nx;
      ir_valid  <= ir_valid_nx;
      ir_data   <= ir_data_nx;
      ir_pc     <= ir_pc_nx;
    end
  end

  // Next-state logic; an issued request can never be withdrawn, hence DRAIN
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_REQ;
      S_REQ: begin
        if (br_valid)     state_nx = mem_ack ? S_REQ : S_DRAIN;
        else if (mem_ack) state_nx = S_HOLD;
      end
      S_HOLD:  if (br_valid || ir_ready) state_nx = S_REQ;
      S_DRAIN: if (mem_ack) state_nx = S_REQ;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    pc_inc_nx    = 1'b0;
    pc_load_nx   = 1'b0;
    pc_target_nx = pc_target;
    mem_req_nx   = mem_req;
    mem_addr_nx  = mem_addr;
    ir_valid_nx  = ir_valid;
    ir_data_nx   = ir_data;
    ir_pc_nx     = ir_pc;
    pending_nx   = pending;

    if (br_valid && state != S_IDLE) begin
      pc_load_nx   = 1'b1;
      pc_target_nx = br_target;
      ir_valid_nx  = 1'b0;
    end

    unique case (state)
      S_IDLE: begin
        mem_addr_nx = pc;
        mem_req_nx  = 1'b1;
      end
      S_REQ: begin
        if (br_valid) begin
          if (mem_ack) mem_addr_nx = br_target;
          else         pending_nx  = br_target;
        end else if (mem_ack) begin
          ir_data_nx  = mem_rdata;
          ir_pc_nx    = mem_addr;
          ir_valid_nx = 1'b1;
          mem_req_nx  = 1'b0;
          pc_inc_nx   = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_valid) begin
          mem_addr_nx = br_target;
          mem_req_nx  = 1'b1;
        end else if (ir_ready) begin
          ir_valid_nx = 1'b0;
          mem_addr_nx = ir_pc + ADDR_W'(1);
          mem_req_nx  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (br_valid) pending_nx = br_target;
        if (mem_ack) begin
          mem_addr_nx = br_valid ? br_target : pending;
          mem_req_nx  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
